// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Multi-key state tracker fed by a PS/2 Set-2 byte receiver. Decodes make/break/E0 prefixes,
//   drops the Pause (E1) sequence, and keeps a held/press/release view of NUM_KEYS keys.
//   An inactivity timeout force-releases held keys in case a break code was lost.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   byte_valid   one-cycle strobe, byte_data valid
//   byte_data    received scan byte
//   rx_error     one-cycle strobe, receiver frame/parity error
//   key_held     per-key level, key currently down (registered)
//   key_press    per-key one-cycle pulse on up-to-down transition (registered)
//   key_release  per-key one-cycle pulse on down-to-up transition (registered)
//   any_held     OR of key_held
//   last_key     index of the most recently pressed key (registered)
module ps2_key_tracker #(
    parameter int unsigned NUM_KEYS = 4,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES = {8'h1D, 8'h1B, 8'h23, 8'h1C},
    parameter logic [NUM_KEYS-1:0] KEY_EXT = '0,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    localparam int unsigned KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    input  logic                rx_error,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_held,
    output logic [KW-1:0]       last_key
);

    typedef enum logic [2:0] {StIdle, StE0, StF0, StE0F0, StSkip} state_e;

    state_e              state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic [31:0]         tcnt_q, tcnt_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [KW-1:0]       last_q, last_d;

    logic is_make, is_break, is_ext, is_flush, timeout_hit;

    assign key_held    = held_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign last_key    = last_q;
    assign any_held    = |held_q;

    // Prefix decoder
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        is_ext   = 1'b0;
        is_flush = 1'b0;
        if (rx_error) begin
            // Error drops any partial prefix and any coincident byte.
            state_d = StIdle;
            skip_d  = '0;
        end else if (byte_valid) begin
            case (state_q)
                StIdle: begin
                    if (byte_data == 8'hF0) begin
                        state_d = StF0;
                    end else if (byte_data == 8'hE0) begin
                        state_d = StE0;
                    end else if (byte_data == 8'hE1) begin
                        // Remaining 7 bytes of the Pause sequence
                        state_d = StSkip;
                        skip_d  = 3'd7;
                    end else if (byte_data == 8'hAA || byte_data == 8'hFC ||
                                 byte_data == 8'h00 || byte_data == 8'hFF) begin
                        is_flush = 1'b1;
                    end else if (byte_data == 8'hFA || byte_data == 8'hFE ||
                                 byte_data == 8'hEE) begin
                        is_flush = 1'b0;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                StE0: begin
                    state_d = StIdle;
                    if (byte_data == 8'hF0) begin
                        state_d = StE0F0;
                    end else if (byte_data != 8'h12 && byte_data != 8'h59) begin
                        // 12/59 after E0 are fake shifts and are discarded
                        is_make = 1'b1;
                        is_ext  = 1'b1;
                    end
                end
                StF0: begin
                    state_d  = StIdle;
                    is_break = 1'b1;
                end
                StE0F0: begin
                    state_d  = StIdle;
                    is_break = 1'b1;
                    is_ext   = 1'b1;
                end
                StSkip: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        state_d = StIdle;
                        skip_d  = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Inactivity timeout; a byte in the same cycle takes priority over the forced flush.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && any_held && !byte_valid &&
                      (tcnt_q == TIMEOUT_CYCLES - 1);
        tcnt_d = tcnt_q;
        if (byte_valid || !any_held || timeout_hit) begin
            tcnt_d = '0;
        end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 32'd1;
        end
    end

    // Key state update
    always_comb begin
        held_d    = held_q;
        press_d   = '0;
        release_d = '0;
        last_d    = last_q;
        if (is_flush || timeout_hit) begin
            release_d = held_q;
            held_d    = '0;
        end else begin
            // Descending so the lowest matching index ends up in last_key.
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                if (byte_data == KEY_CODES[8*i +: 8] && is_ext == KEY_EXT[i]) begin
                    if (is_make && !held_q[i]) begin
                        held_d[i]  = 1'b1;
                        press_d[i] = 1'b1;
                        last_d     = KW'(i);
                    end
                    if (is_break && held_q[i]) begin
                        held_d[i]    = 1'b0;
                        release_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            skip_q    <= '0;
            tcnt_q    <= '0;
            held_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            tcnt_q    <= tcnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: a 4-key instance (default codes, short timeout) and a 1-key
// extended-code instance share clock/reset; sel_e routes byte strobes to one or the other.
module tb_ps2_key_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       bv = 1'b0, err = 1'b0, sel_e = 1'b0;
    logic [7:0] bd = 8'h00;
    logic       bv_m, bv_x, err_m, err_x;

    assign bv_m  = bv & ~sel_e;
    assign err_m = err & ~sel_e;
    assign bv_x  = bv & sel_e;
    assign err_x = err & sel_e;

    logic [3:0] held, press, rel;
    logic       any;
    logic [1:0] last;
    logic       x_held, x_press, x_rel, x_any;
    logic [0:0] x_last;

    ps2_key_tracker #(
        .NUM_KEYS(4),
        .KEY_CODES(32'h1D1B231C),
        .KEY_EXT(4'b0000),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .byte_valid(bv_m), .byte_data(bd), .rx_error(err_m),
        .key_held(held), .key_press(press), .key_release(rel), .any_held(any),
        .last_key(last)
    );

    ps2_key_tracker #(
        .NUM_KEYS(1),
        .KEY_CODES(8'h74),
        .KEY_EXT(1'b1),
        .TIMEOUT_CYCLES(0)
    ) dut_e (
        .clk(clk), .rst(rst), .byte_valid(bv_x), .byte_data(bd), .rx_error(err_x),
        .key_held(x_held), .key_press(x_press), .key_release(x_rel), .any_held(x_any),
        .last_key(x_last)
    );

    typedef logic [19:0] obs_t;
    obs_t exp_q[$];
    obs_t obs_q[$];
    int   checks = 0;
    int   errors = 0;

    // Expected output word: main held/press/release/last/any, then ext held/press/release/any/last.
    function automatic obs_t mk(input logic [3:0] h, input logic [3:0] p, input logic [3:0] r,
                                input logic [1:0] l, input logic [2:0] e);
        return {h, p, r, l, |h, e, e[2], 1'b0};
    endfunction

    // Drive one cycle, queue its expected result, record what the DUTs produce after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic e, input obs_t x);
        @(negedge clk);
        bv = v;
        bd = d;
        err = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        obs_q.push_back({held, press, rel, last, any, x_held, x_press, x_rel, x_any, x_last});
    endtask

    task automatic do_reset;
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b000));
        rst = 1'b1;
    endtask

    task automatic test_reset;
        obs_t x, o;
        int n = 0;
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b000));
        step(1'b1, 8'h1C, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b000));
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b000));
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL reset step %0d: no output recorded, expected %h", n, x);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    errors++;
                    $display("FAIL reset step %0d: got %h expected %h", n, o, x);
                end
            end
            n++;
        end
    endtask

    task automatic test_make_break;
        obs_t x, o;
        int n = 0;
        do_reset();
        step(1'b1, 8'h1C, 1'b0, mk(4'b0001, 4'b0001, 4'b0000, 2'd0, 3'b000));
        step(1'b0, 8'h00, 1'b0, mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 3'b000));
        step(1'b1, 8'hF0, 1'b0, mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 3'b000));
        step(1'b1, 8'h1C, 1'b0, mk(4'b0000, 4'b0000, 4'b0001, 2'd0, 3'b000));
        step(1'b0, 8'h00, 1'b0, mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 3'b000));
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL make_break step %0d: no output recorded, expected %h", n, x);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    errors++;
                    $display("FAIL make_break step %0d: got %h expected %h", n, o, x);
                end
            end
            n++;
        end
    endtask

    task automatic test_multi_typematic;
        obs_t x, o;
        int n = 0;
        do_reset();
        step(1'b1, 8'h1D, 1'b0, mk(4'b1000, 4'b1000, 4'b0000, 2'd3, 3'b000));
        step(1'b1, 8'h23, 1'b0, mk(4'b1010, 4'b0010, 4'b0000, 2'd1, 3'b000));
        step(1'b1, 8'h1D, 1'b0, mk(4'b1010, 4'b0000, 4'b0000, 2'd1, 3'b000));
        step(1'b1, 8'h1D, 1'b0, mk(4'b1010, 4'b0000, 4'b0000, 2'd1, 3'b000));
        step(1'b1, 8'hF0, 1'b0, mk(4'b1010, 4'b0000, 4'b0000, 2'd1, 3'b000));
        step(1'b1, 8'h23, 1'b0, mk(4'b1000, 4'b0000, 4'b0010, 2'd1, 3'b000));
        step(1'b0, 8'h00, 1'b0, mk(4'b1000, 4'b0000, 4'b0000, 2'd1, 3'b000));
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL multi_typematic step %0d: no output recorded, expected %h", n, x);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    errors++;
                    $display("FAIL multi_typematic step %0d: got %h expected %h", n, o, x);
                end
            end
            n++;
        end
    endtask

    task automatic test_extended;
        obs_t x, o;
        int n = 0;
        do_reset();
        sel_e = 1'b1;
        step(1'b1, 8'h74, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b000));
        step(1'b1, 8'hE0, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b000));
        step(1'b1, 8'h74, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b110));
        step(1'b1, 8'hF0, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b100));
        step(1'b1, 8'h74, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b100));
        step(1'b1, 8'hE0, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b100));
        step(1'b1, 8'hF0, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b100));
        step(1'b1, 8'h74, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b001));
        step(1'b0, 8'h00, 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b000));
        sel_e = 1'b0;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL extended step %0d: no output recorded, expected %h", n, x);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    errors++;
                    $display("FAIL extended step %0d: got %h expected %h", n, o, x);
                end
            end
            n++;
        end
    endtask

    task automatic test_pause_error;
        obs_t x, o;
        int n = 0;
        logic [7:0] pause [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        do_reset();
        foreach (pause[i]) step(1'b1, pause[i], 1'b0, mk(4'b0, 4'b0, 4'b0, 2'd0, 3'b000));
        step(1'b1, 8'h1C, 1'b0, mk(4'b0001, 4'b0001, 4'b0000, 2'd0, 3'b000));
        // Errored F0 must not arm a break.
        step(1'b1, 8'hF0, 1'b1, mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 3'b000));
        step(1'b1, 8'h1C, 1'b0, mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 3'b000));
        // Standalone error after F0 discards the prefix.
        step(1'b1, 8'hF0, 1'b0, mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 3'b000));
        step(1'b0, 8'h00, 1'b1, mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 3'b000));
        step(1'b1, 8'h1C, 1'b0, mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 3'b000));
        step(1'b0, 8'h00, 1'b0, mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 3'b000));
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL pause_error step %0d: no output recorded, expected %h", n, x);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    errors++;
                    $display("FAIL pause_error step %0d: got %h expected %h", n, o, x);
                end
            end
            n++;
        end
    endtask

    task automatic test_flush;
        obs_t x, o;
        int n = 0;
        do_reset();
        step(1'b1, 8'h1C, 1'b0, mk(4'b0001, 4'b0001, 4'b0000, 2'd0, 3'b000));
        step(1'b1, 8'h23, 1'b0, mk(4'b0011, 4'b0010, 4'b0000, 2'd1, 3'b000));
        step(1'b1, 8'hFA, 1'b0, mk(4'b0011, 4'b0000, 4'b0000, 2'd1, 3'b000));
        step(1'b1, 8'hAA, 1'b0, mk(4'b0000, 4'b0000, 4'b0011, 2'd1, 3'b000));
        step(1'b0, 8'h00, 1'b0, mk(4'b0000, 4'b0000, 4'b0000, 2'd1, 3'b000));
        step(1'b1, 8'h1B, 1'b0, mk(4'b0100, 4'b0100, 4'b0000, 2'd2, 3'b000));
        step(1'b1, 8'h00, 1'b0, mk(4'b0000, 4'b0000, 4'b0100, 2'd2, 3'b000));
        step(1'b0, 8'h00, 1'b0, mk(4'b0000, 4'b0000, 4'b0000, 2'd2, 3'b000));
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL flush step %0d: no output recorded, expected %h", n, x);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    errors++;
                    $display("FAIL flush step %0d: got %h expected %h", n, o, x);
                end
            end
            n++;
        end
    endtask

    task automatic test_timeout;
        obs_t x, o;
        int n = 0;
        do_reset();
        step(1'b1, 8'h1C, 1'b0, mk(4'b0001, 4'b0001, 4'b0000, 2'd0, 3'b000));
        // Release lands 100 cycles after the make became visible.
        for (int i = 1; i <= 101; i++) begin
            if (i < 100)
                step(1'b0, 8'h00, 1'b0, mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 3'b000));
            else if (i == 100)
                step(1'b0, 8'h00, 1'b0, mk(4'b0000, 4'b0000, 4'b0001, 2'd0, 3'b000));
            else
                step(1'b0, 8'h00, 1'b0, mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 3'b000));
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL timeout step %0d: no output recorded, expected %h", n, x);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    errors++;
                    $display("FAIL timeout step %0d: got %h expected %h", n, o, x);
                end
            end
            n++;
        end
    endtask

    task automatic test_reset_midop;
        obs_t x, o;
        int n = 0;
        do_reset();
        step(1'b1, 8'h1C, 1'b0, mk(4'b0001, 4'b0001, 4'b0000, 2'd0, 3'b000));
        step(1'b1, 8'h23, 1'b0, mk(4'b0011, 4'b0010, 4'b0000, 2'd1, 3'b000));
        step(1'b1, 8'hF0, 1'b0, mk(4'b0011, 4'b0000, 4'b0000, 2'd1, 3'b000));
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 3'b000));
        rst = 1'b1;
        step(1'b1, 8'h23, 1'b0, mk(4'b0010, 4'b0010, 4'b0000, 2'd1, 3'b000));
        step(1'b0, 8'h00, 1'b0, mk(4'b0010, 4'b0000, 4'b0000, 2'd1, 3'b000));
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL reset_midop step %0d: no output recorded, expected %h", n, x);
            end else begin
                o = obs_q.pop_front();
                if (o !== x) begin
                    errors++;
                    $display("FAIL reset_midop step %0d: got %h expected %h", n, o, x);
                end
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_multi_typematic();
        test_extended();
        test_pause_error();
        test_flush();
        test_timeout();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
